fifo_block_assembler: RTL and testbench
=======================================

FIFO_BLOCK_ASSEMBLER -- requirements
Module: fifo_block_assembler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  - WIDTH, 8, FIFO byte width in bits.
  - BLOCK_BYTES, 16, bytes per output block; block width is WIDTH*BLOCK_BYTES = 128.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  - i_clk, in, 1, single clock; all logic on its rising edge.
  - i_rst_n, in, 1, asynchronous active-low reset.
  - i_fifo_empty, in, 1, FIFO o_empty.
  - i_fifo_rd_data, in, WIDTH, FIFO o_rd_data; valid the cycle after the read strobe.
  - o_fifo_rd_en, out, 1, FIFO read strobe.
  - i_flush, in, 1, request to close a partial block (see Configuration).
  - o_blk_data, out, 128, assembled block.
  - o_blk_valid, out, 1, block available.
  - i_blk_ready, in, 1, cipher core accepts the block.
  - o_busy, out, 1, partial block held or read outstanding.

Function
REQ-003 The FSM SHALL have exactly two states: FILL and HOLD.
REQ-004 In FILL, o_fifo_rd_en SHALL be combinational: !i_fifo_empty && issued < BLOCK_BYTES.
REQ-005 The issued count SHALL increment on every cycle with o_fifo_rd_en=1.
REQ-006 Data SHALL be captured one cycle after each strobe, at a fixed 1-cycle FIFO read latency.
REQ-007 Each captured byte SHALL increment the captured count.
REQ-008 Byte order SHALL be big-endian: the first byte popped lands in o_blk_data[127:120], the 16th in [7:0].
REQ-009 On the edge that captures byte BLOCK_BYTES, the FSM SHALL enter HOLD, so o_blk_valid=1 from the next cycle.
  - With a non-empty FIFO this gives strobes in cycles 0..15 and o_blk_valid in cycle 17.
REQ-010 In HOLD, o_fifo_rd_en SHALL be 0.
REQ-011 In HOLD, o_blk_data SHALL be stable and o_blk_valid SHALL stay 1 until i_blk_ready=1.
REQ-012 On the HOLD edge with o_blk_valid && i_blk_ready, the FSM SHALL:
  - return to FILL;
  - clear both counts;
  - drop o_blk_valid.
  Reads resume the following cycle, giving a one-cycle bubble.
REQ-013 i_blk_ready while o_blk_valid=0 SHALL have no effect.
REQ-014 i_fifo_empty rising mid-block SHALL stall issuing without losing the partial block.
  - Any outstanding read SHALL still be captured.
REQ-015 The issued count SHALL never exceed BLOCK_BYTES, so no read is issued beyond the block boundary.
REQ-016 o_busy SHALL equal (captured != 0) || (issued != captured) || (state == HOLD).

Reset
REQ-017 i_rst_n=0 SHALL asynchronously force:
  - state FILL;
  - both counts 0;
  - o_blk_data 0;
  - o_blk_valid 0.
  The combinational o_fifo_rd_en SHALL also read 0 while i_rst_n=0.
REQ-018 Reset mid-block SHALL discard the partial block.
  - Data returning for a strobe issued before reset SHALL be ignored; that byte is lost by design.
REQ-019 After deassertion, the first strobe SHALL occur no earlier than the first clock edge with i_rst_n=1.

Configuration
REQ-020 With FIFO_BLOCK_PAD_EN defined, i_flush SHALL close a partial block.
  - Condition: i_flush=1 in FILL with captured >= 1 and issued == captured.
  - Action: unfilled bytes are set to the PKCS#7 value (BLOCK_BYTES - captured) and the FSM enters HOLD on that edge.
  - o_fifo_rd_en SHALL be 0 in any cycle with i_flush=1.
  - i_flush with captured=0 SHALL be ignored.
REQ-021 Without FIFO_BLOCK_PAD_EN, i_flush SHALL be ignored entirely and only full blocks are emitted.
  - The port remains present in both builds.

Structure
REQ-022 Package enc_pkg SHALL hold:
  - BYTE_W=8, BLOCK_BYTES=16 and BLOCK_W=128 constants;
  - the FSM state typedef (FILL, HOLD).
REQ-023 The block SHALL be one flat module with no sub-module.
  - Its shift/insert register, counters and FSM are too small to justify one.

Verification
REQ-024 Reset then 16 bytes 00..0F preloaded, i_blk_ready=1 -> o_blk_valid in cycle 17 with o_blk_data=000102..0F.
  - o_fifo_rd_en high exactly 16 cycles.
REQ-025 20 bytes preloaded, i_blk_ready=0 for 10 cycles after valid -> o_blk_data and o_blk_valid are stable throughout.
  - No strobe in HOLD.
  - After the handshake, 4 more bytes are captured and o_busy=1.
REQ-026 Empty toggles every other cycle while feeding AA x16 -> the block is AA repeated 16 times.
  - The issued count never exceeds 16; no byte is duplicated or dropped.
REQ-027 i_rst_n pulsed low after 7 captures -> outputs 0 immediately.
  - The next block is formed only from bytes popped after reset.
REQ-028 FIFO_BLOCK_PAD_EN build with 11 bytes 11..1B then i_flush -> o_blk_data=111213..1B followed by five 05 bytes.
  - Without the macro, the same stimulus yields no o_blk_valid.

Source files
------------

// File: rtl/fifo_block_assembler_pkg.sv
// Shared constants and FSM state type for the FIFO-to-block assembler.
package enc_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BLOCK_W     = BYTE_W * BLOCK_BYTES;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_block_assembler.sv
// Pops bytes from a 1-cycle-latency FIFO and assembles big-endian blocks for a cipher core.
// Optional FIFO_BLOCK_PAD_EN: i_flush closes a partial block with PKCS#7 padding.
module fifo_block_assembler #(
    parameter int unsigned WIDTH       = enc_pkg::BYTE_W,
    parameter int unsigned BLOCK_BYTES = enc_pkg::BLOCK_BYTES
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_fifo_empty,
    input  logic [WIDTH-1:0]               i_fifo_rd_data,
    output logic                           o_fifo_rd_en,
    input  logic                           i_flush,
    output logic [WIDTH*BLOCK_BYTES-1:0]   o_blk_data,
    output logic                           o_blk_valid,
    input  logic                           i_blk_ready,
    output logic                           o_busy
);
    import enc_pkg::*;

    localparam int unsigned BLK_W = WIDTH * BLOCK_BYTES;
    localparam int unsigned CNT_W = $clog2(BLOCK_BYTES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_BYTES);

`ifdef FIFO_BLOCK_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  captured_q, captured_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              valid_q, busy_q, busy_d;

    logic              flush_req;
    logic              capture;
    logic              flush_ok;
    logic [CNT_W-1:0]  pad_cnt;
    logic [WIDTH-1:0]  pad_byte;
    logic [BLK_W-1:0]  padded;

    assign flush_req = PAD_EN & i_flush;

    // Read strobe is gated by reset so nothing is popped while the block is held in reset.
    assign o_fifo_rd_en = i_rst_n && (state_q == FILL) && !i_fifo_empty
                          && (issued_q < FULL_CNT) && !flush_req;

    // With a fixed 1-cycle latency, an uncaptured issue means data is on the bus now.
    assign capture  = (state_q == FILL) && (issued_q != captured_q);
    assign flush_ok = flush_req && (state_q == FILL) && (captured_q != '0)
                      && (issued_q == captured_q);

    // Shift the captured bytes to the top and fill the tail with the pad count.
    always_comb begin
        pad_cnt  = FULL_CNT - captured_q;
        pad_byte = WIDTH'(pad_cnt);
        padded   = blk_q;
        for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
            if (k < 32'(pad_cnt)) begin
                padded = {padded[BLK_W-WIDTH-1:0], pad_byte};
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        captured_d = captured_q;
        blk_d      = blk_q;
        case (state_q)
            FILL: begin
                if (o_fifo_rd_en) begin
                    issued_d = issued_q + CNT_W'(1);
                end
                if (capture) begin
                    blk_d      = {blk_q[BLK_W-WIDTH-1:0], i_fifo_rd_data};
                    captured_d = captured_q + CNT_W'(1);
                    if (captured_q == FULL_CNT - CNT_W'(1)) begin
                        state_d = HOLD;
                    end
                end else if (flush_ok) begin
                    blk_d   = padded;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (i_blk_ready) begin
                    state_d    = FILL;
                    issued_d   = '0;
                    captured_d = '0;
                end
            end
        endcase
        busy_d = (captured_d != '0) || (issued_d != captured_d) || (state_d == HOLD);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= FILL;
            issued_q   <= '0;
            captured_q <= '0;
            blk_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            captured_q <= captured_d;
            blk_q      <= blk_d;
            valid_q    <= (state_d == HOLD);
            busy_q     <= busy_d;
        end
    end

    assign o_blk_data  = blk_q;
    assign o_blk_valid = valid_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_fifo_block_assembler.sv
// Scoreboard bench: a FIFO model feeds the assembler; popped bytes form expected blocks.
module tb_fifo_block_assembler;

    localparam int unsigned NB = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fifo_empty;
    logic [7:0]   rd_data;
    logic         rd_en;
    logic         flush;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         busy;

    logic [7:0]   fifo_q[$];
    int           fifo_cnt;
    logic         stall;
    logic [7:0]   partial[$];
    logic [127:0] exp_q[$];

    int checks;
    int errors;
    int cyc;
    int first_rd;
    int first_v;
    int rd_cnt;
    int valid_seen;
    int strobes_blk;

    logic         prev_valid;
    logic         prev_hs;
    logic [127:0] prev_data;

    assign fifo_empty = (fifo_cnt == 0) || stall;

    always #5 clk = ~clk;

    fifo_block_assembler dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_fifo_empty   (fifo_empty),
        .i_fifo_rd_data (rd_data),
        .o_fifo_rd_en   (rd_en),
        .i_flush        (flush),
        .o_blk_data     (blk_data),
        .o_blk_valid    (blk_valid),
        .i_blk_ready    (blk_ready),
        .o_busy         (busy)
    );

    // Block as the byte stream says it should be: first popped byte on top, tail padded.
    function automatic logic [127:0] model_block(input logic [7:0] pad);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < NB; i++) begin
            b[127-8*i -: 8] = (i < partial.size()) ? partial[i] : pad;
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_cnt = fifo_q.size();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 128'(blk_valid), 128'(0));
        chk("rst_data", blk_data, 128'(0));
        chk("rst_rd_en", 128'(rd_en), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        partial.delete();
        run(2);
        rst_n = 1'b1;
    endtask

    // FIFO model: a strobe seen mid-cycle pops one byte that appears after the next edge.
    initial begin
        logic strobe;
        forever begin
            @(negedge clk);
            strobe = rd_en;
            @(posedge clk);
            #1;
            if (strobe) begin
                checks++;
                if (fifo_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_empty: got strobe with empty fifo, required none");
                end else begin
                    rd_data  = fifo_q.pop_front();
                    fifo_cnt = fifo_q.size();
                    partial.push_back(rd_data);
                    if (partial.size() == NB) begin
                        exp_q.push_back(model_block(8'h00));
                        partial.delete();
                    end
                end
            end
        end
    end

    // Monitor: handshakes, hold stability, read limits.
    initial begin
        logic         hs;
        logic [127:0] e;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (rd_en) begin
                    if (first_rd < 0) first_rd = cyc;
                    if (first_v < 0) rd_cnt++;
                    strobes_blk++;
                    checks++;
                    if (blk_valid || strobes_blk > NB) begin
                        errors++;
                        $display("FAIL rd_limit: got strobe %0d valid %0d, required <=%0d and valid 0",
                                 strobes_blk, blk_valid, NB);
                    end
                end
`ifdef FIFO_BLOCK_PAD_EN
                if (flush) chk("rd_during_flush", 128'(rd_en), 128'(0));
`endif
                if (blk_valid) begin
                    valid_seen++;
                    if (first_v < 0) first_v = cyc;
                    if (prev_valid && !prev_hs) chk("hold_stable", blk_data, prev_data);
                end
                hs = blk_valid && blk_ready;
                if (hs) begin
                    strobes_blk = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_block: got %h, required no block", blk_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("block", blk_data, e);
                    end
                end
                prev_valid = blk_valid;
                prev_data  = blk_data;
                prev_hs    = hs;
            end else begin
                prev_valid  = 1'b0;
                prev_hs     = 1'b0;
                strobes_blk = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int rel;
        int v0;
        int pushed;
        logic [7:0] b;
        checks = 0; errors = 0; cyc = 0;
        first_rd = -1; first_v = -1; rd_cnt = 0; valid_seen = 0; strobes_blk = 0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; blk_ready = 1'b0;
        rd_data = '0; fifo_cnt = 0;
        #1;
        chk("reset_valid", 128'(blk_valid), 128'(0));
        chk("reset_data", blk_data, 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));

        // Preloaded 00..0F, ready high: strobes cycles 0..15, valid at cycle 17.
        for (int i = 0; i < 16; i++) push(8'(i));
        run(3);
        chk("rd_en_in_reset", 128'(rd_en), 128'(0));
        blk_ready = 1'b1;
        first_rd = -1; first_v = -1; rd_cnt = 0;
        rel = cyc;
        rst_n = 1'b1;
        run(30);
        chk("first_strobe_cycle", 128'(first_rd - rel), 128'(1));
        chk("valid_latency", 128'(first_v - first_rd), 128'(17));
        chk("strobe_count", 128'(rd_cnt), 128'(16));
        chk("drain1", 128'(exp_q.size()), 128'(0));

        // 20 bytes, ready held low 10 cycles after valid.
        blk_ready = 1'b0;
        for (int i = 0; i < 20; i++) push(8'($urandom_range(0, 255)));
        for (int i = 0; i < 60 && !blk_valid; i++) run(1);
        chk("hold_valid_seen", 128'(blk_valid), 128'(1));
        run(10);
        chk("hold_valid_kept", 128'(blk_valid), 128'(1));
        blk_ready = 1'b1;
        run(1);
        blk_ready = 1'b0;
        run(8);
        chk("after_hs_valid", 128'(blk_valid), 128'(0));
        chk("after_hs_busy", 128'(busy), 128'(1));
        chk("after_hs_bytes", 128'(partial.size()), 128'(4));
        for (int i = 0; i < 12; i++) push(8'($urandom_range(0, 255)));
        blk_ready = 1'b1;
        run(30);
        chk("drain2", 128'(exp_q.size()), 128'(0));

        // Empty toggling every cycle while feeding AA x16.
        for (int i = 0; i < 16; i++) push(8'hAA);
        for (int i = 0; i < 60; i++) begin
            stall = 1'(i % 2);
            run(1);
        end
        stall = 1'b0;
        run(10);
        chk("drain_aa", 128'(exp_q.size()), 128'(0));
        chk("aa_partial", 128'(partial.size()), 128'(0));

        // Reset after 7 captures, with a read in flight: partial block discarded.
        for (int i = 0; i < 7; i++) push(8'($urandom_range(0, 255)));
        run(12);
        chk("seven_busy", 128'(busy), 128'(1));
        for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
        do_reset();
        for (int i = 0; i < 12; i++) push(8'($urandom_range(0, 255)));
        run(40);
        chk("drain_post_reset", 128'(exp_q.size()), 128'(0));
        chk("post_reset_partial", 128'(partial.size()), 128'(0));

        // Random bytes, random FIFO stalls, random back-pressure.
        pushed = 0;
        for (int c = 0; c < 400; c++) begin
            stall     = ($urandom_range(0, 2) == 0);
            blk_ready = 1'($urandom_range(0, 1));
            if (pushed < 48 && $urandom_range(0, 1) == 1) begin
                push(8'($urandom_range(0, 255)));
                pushed++;
            end
            run(1);
        end
        for (; pushed < 48; pushed++) push(8'($urandom_range(0, 255)));
        stall = 1'b0;
        blk_ready = 1'b1;
        run(80);
        chk("drain_random", 128'(exp_q.size()), 128'(0));
        chk("random_partial", 128'(partial.size()), 128'(0));

        // Flush with nothing captured is ignored in every build.
        v0 = valid_seen;
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        run(5);
        chk("flush_empty_ignored", 128'(valid_seen - v0), 128'(0));
        chk("flush_empty_busy", 128'(busy), 128'(0));

        // 11 bytes 11..1B then flush.
        for (int i = 0; i < 11; i++) push(8'(8'h11 + i));
        run(20);
        chk("eleven_busy", 128'(busy), 128'(1));
        v0 = valid_seen;
        flush = 1'b1;
`ifdef FIFO_BLOCK_PAD_EN
        b = 8'(NB - partial.size());
        exp_q.push_back(model_block(b));
        partial.delete();
`endif
        run(1);
        flush = 1'b0;
        run(25);
`ifdef FIFO_BLOCK_PAD_EN
        chk("flush_block_out", 128'(exp_q.size()), 128'(0));
        chk("flush_seen", 128'(valid_seen - v0 > 0), 128'(1));
`else
        chk("flush_no_valid", 128'(valid_seen - v0), 128'(0));
        chk("flush_partial_kept", 128'(partial.size()), 128'(11));
        do_reset();
`endif
        run(5);
        chk("final_exp_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
